// File: rtl/soc_rst_pkg.sv
// soc_rst_pkg -- shared definitions for the SoC reset sequencer.
//   rst_state_e : FSM state encoding (also exported on the debug port)
//   *_MIN/_MAX  : legal ranges of the sequencer parameters
//   cnt_width() : counter width for a given cycle limit ($clog2 + 1, never wraps)
package soc_rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } rst_state_e;

    localparam int unsigned NUM_CH_MIN = 1;
    localparam int unsigned NUM_CH_MAX = 8;
    localparam int unsigned HOLD_MIN   = 1;
    localparam int unsigned HOLD_MAX   = 65535;
    localparam int unsigned GAP_MIN    = 1;
    localparam int unsigned GAP_MAX    = 65535;
    localparam int unsigned WDOG_MIN   = 1;
    localparam int unsigned WDOG_MAX   = (1 << 20) - 1;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/rst_cycle_counter.sv
// rst_cycle_counter -- up-counter with synchronous clear and terminal-count flag.
//   clk, reset : clock, asynchronous active-low reset
//   load_i     : clear the count to zero (wins over en_i)
//   en_i       : count up by one; the count holds once it reaches term_i
//   term_i     : terminal value
//   tc_o       : high while the count equals term_i
module rst_cycle_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == term_i);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/soc_reset_sequencer.sv
// soc_reset_sequencer -- holds all reset channels, releases them one by one,
// then watches the SoC with a heartbeat watchdog until done or timeout.
//   clk, reset    : clock, asynchronous active-low reset
//   sw_rst_req    : restart the whole sequence (highest priority)
//   heartbeat     : SoC activity strobe, restarts the watchdog while running
//   done_in       : SoC completion, latched into finished while running
//   ch_rst        : per-channel active-high reset, bit 0 released first
//   all_released  : registered "every channel released"
//   finished      : sticky completion flag
//   timeout       : sticky watchdog expiry flag
//   state         : FSM state for debug
module soc_reset_sequencer
    import soc_rst_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned WDOG_CYCLES = 700
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_rst_req,
    input  logic              heartbeat,
    input  logic              done_in,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              all_released,
    output logic              finished,
    output logic              timeout,
    output logic [2:0]        state
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
        HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > HOLD_MAX ||
        GAP_CYCLES < GAP_MIN || GAP_CYCLES > GAP_MAX ||
        WDOG_CYCLES < WDOG_MIN || WDOG_CYCLES > WDOG_MAX) begin : g_bad_params
        $error("soc_reset_sequencer: parameter outside legal range");
    end

    // Hold and gap phases never overlap, so they share one counter sized for the larger.
    localparam int unsigned HG_LIMIT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned HG_W     = cnt_width(HG_LIMIT);
    localparam int unsigned WD_W     = cnt_width(WDOG_CYCLES);
    localparam logic [HG_W-1:0] HOLD_TERM = HG_W'(HOLD_CYCLES - 1);
    localparam logic [HG_W-1:0] GAP_TERM  = HG_W'(GAP_CYCLES - 1);
    localparam logic [WD_W-1:0] WDOG_TERM = WD_W'(WDOG_CYCLES - 1);

    rst_state_e        state_q, state_d;
    logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
    logic              all_rel_q, all_rel_d;
    logic              finished_q, finished_d;
    logic              timeout_q, timeout_d;

    logic            seq_phase;
    logic            hg_load, hg_tc;
    logic [HG_W-1:0] hg_term;
    logic            wd_load, wd_en, wd_tc;

    assign seq_phase = (state_q == ST_HOLD) || (state_q == ST_RELEASE);

    // Restarts on every terminal count so each gap is measured from the previous release.
    assign hg_load = sw_rst_req || hg_tc || !seq_phase;
    assign hg_term = (state_q == ST_HOLD) ? HOLD_TERM : GAP_TERM;

    assign wd_en   = (state_q == ST_RUN);
    assign wd_load = sw_rst_req || heartbeat || !wd_en;

    rst_cycle_counter #(.WIDTH(HG_W)) u_hold_gap_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (hg_load),
        .en_i   (seq_phase),
        .term_i (hg_term),
        .tc_o   (hg_tc)
    );

    rst_cycle_counter #(.WIDTH(WD_W)) u_wdog_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (wd_load),
        .en_i   (wd_en),
        .term_i (WDOG_TERM),
        .tc_o   (wd_tc)
    );

    always_comb begin
        state_d    = state_q;
        ch_rst_d   = ch_rst_q;
        finished_d = finished_q;
        timeout_d  = timeout_q;
        all_rel_d  = !sw_rst_req && (ch_rst_q == '0);
        if (sw_rst_req) begin
            state_d    = ST_HOLD;
            ch_rst_d   = '1;
            finished_d = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hg_tc) begin
                        state_d  = ST_RELEASE;
                        ch_rst_d = ch_rst_q << 1;
                    end
                end
                ST_RELEASE: begin
                    // Zero-fill shift releases the lowest still-held channel.
                    if (ch_rst_q == '0)
                        state_d = ST_RUN;
                    else if (hg_tc)
                        ch_rst_d = ch_rst_q << 1;
                end
                ST_RUN: begin
                    if (done_in) begin
                        state_d    = ST_DONE;
                        finished_d = 1'b1;
                    end else if (!heartbeat && wd_tc) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
                ST_DONE, ST_TIMEOUT: ;
                default: begin
                    state_d  = ST_HOLD;
                    ch_rst_d = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HOLD;
            ch_rst_q   <= '1;
            all_rel_q  <= 1'b0;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_rst_q   <= ch_rst_d;
            all_rel_q  <= all_rel_d;
            finished_q <= finished_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ch_rst       = ch_rst_q;
    assign all_released = all_rel_q;
    assign finished     = finished_q;
    assign timeout      = timeout_q;
    assign state        = state_q;

endmodule

// File: doc/soc_reset_sequencer.md
SOC_RESET_SEQUENCER -- requirements
Module: soc_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sequenced reset channels (legal 1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, cycles all channels stay asserted after reset (legal 1..65535).
REQ-003 SHALL have parameter GAP_CYCLES, default 8, cycles between successive channel releases (legal 1..65535).
REQ-004 SHALL have parameter WDOG_CYCLES, default 700, idle cycles without heartbeat before timeout (legal 1..2^20-1).
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sw_rst_req  input  1  single-cycle request to re-run the full reset sequence.
REQ-008 SHALL have port heartbeat  input  1  activity strobe from the SoC; any high cycle restarts the watchdog.
REQ-009 SHALL have port done_in  input  1  SoC reports test completion.
REQ-010 SHALL have port ch_rst  output  NUM_CH  active-high reset per channel; bit 0 released first.
REQ-011 SHALL have port all_released  output  1  high while every ch_rst bit is low.
REQ-012 SHALL have port finished  output  1  sticky: done_in seen while running.
REQ-013 SHALL have port timeout  output  1  sticky: watchdog expired while running.
REQ-014 SHALL have port state  output  3  current FSM state encoding, for debug.

Function
REQ-015 SHALL implement FSM states HOLD=0, RELEASE=1, RUN=2, DONE=3, TIMEOUT=4.
REQ-016 SHALL on reset low enter HOLD with ch_rst all ones, all_released=0, finished=0, timeout=0, counters zero.
REQ-017 SHALL in HOLD count HOLD_CYCLES clock edges after reset release, then enter RELEASE and clear ch_rst[0] on that same edge.
REQ-018 SHALL in RELEASE clear ch_rst[k] exactly GAP_CYCLES cycles after ch_rst[k-1] cleared; once ch_rst[NUM_CH-1] clears, enter RUN next edge.
REQ-019 SHALL with NUM_CH=1 go HOLD -> RELEASE -> RUN without any gap wait.
REQ-020 SHALL assert all_released registered, one cycle after the last ch_rst bit clears, and hold it through RUN, DONE and TIMEOUT.
REQ-021 SHALL in RUN increment a watchdog counter each cycle, clear it to zero on any cycle with heartbeat=1.
REQ-022 SHALL in RUN, when the counter reaches WDOG_CYCLES-1 with heartbeat=0, enter TIMEOUT and set timeout on the next edge.
REQ-023 SHALL in RUN, on done_in=1, enter DONE and set finished; done_in takes priority over a coincident watchdog expiry.
REQ-024 SHALL ignore heartbeat and done_in in HOLD and RELEASE; the watchdog counter stays zero there.
REQ-025 SHALL treat DONE and TIMEOUT as terminal: ch_rst stays all zero; leave only via sw_rst_req or reset.
REQ-026 SHALL on sw_rst_req=1 in any state enter HOLD next edge, set ch_rst all ones, clear all counters, all_released, finished, timeout.
REQ-027 SHALL give sw_rst_req priority over done_in and watchdog expiry in the same cycle.
REQ-028 SHALL size counters as $clog2 of their limit plus one bit; no counter wraps.

Reset
REQ-029 SHALL apply reset asynchronously to every flop; deassertion need not be synchronised inside the block.
REQ-030 SHALL assert ch_rst all ones combinationally-immediately with reset low, before any clock edge.
REQ-031 SHALL restart the full sequence from HOLD on reset mid-sequence or mid-run.

Structure
REQ-032 SHALL place state encodings and parameter legal-range constants in shared package soc_rst_pkg.
REQ-033 SHALL contain one sub-module, rst_cycle_counter (load, enable, terminal-count output), instantiated for hold/gap and watchdog.
REQ-034 SHALL be synthesisable; no delays, $finish or dump calls inside the block.

Verification
REQ-035 SHALL cover defaults, reset high at 5 ns, 10 ns clk -> ch_rst 4'b1110 after 16 edges, then bits clear every 8 edges, all_released one cycle after 4'b0000.
REQ-036 SHALL cover heartbeat every 100 cycles for 2000 cycles -> timeout stays 0, state stays RUN.
REQ-037 SHALL cover no heartbeat after RUN entry -> timeout=1 and state=4 exactly 700 cycles later.
REQ-038 SHALL cover done_in and watchdog expiry same cycle -> state=3, finished=1, timeout=0.
REQ-039 SHALL cover sw_rst_req in DONE -> ch_rst=4'b1111, finished=0 next edge, full sequence repeats.
REQ-040 SHALL cover reset pulsed low mid-RELEASE with ch_rst=4'b1100 -> ch_rst=4'b1111 immediately, state=0.
